// File: rtl/button_evt_pkg.sv
// Shared types and default timing for the button event decoder.
//   state_e            : decoder FSM states
//   *_CYCLES_DEF       : default timing constants (clk cycles)
//   max3()             : helper used to size the shared event counter
package button_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HELD,
        GAP,
        DC_HOLD,
        LOCKOUT
    } state_e;

    localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
    localparam int unsigned GAP_CYCLES_DEF    = 12_500_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

    // Largest of three timing limits; sets the counter width.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Switch-side bus of the button event decoder.
//   level/trans_up/trans_dn : debounced level and edge strobes (debouncer -> decoder)
//   short_press/long_press/double_click/repeat_tick : one-cycle event pulses
//   busy                    : decoder is tracking a gesture
// master = debouncer / UI side, slave = decoder.
interface button_event_decoder_if;

    logic level;
    logic trans_up;
    logic trans_dn;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_tick;
    logic busy;

    modport master (
        output level, trans_up, trans_dn,
        input  short_press, long_press, double_click, repeat_tick, busy
    );

    modport slave (
        input  level, trans_up, trans_dn,
        output short_press, long_press, double_click, repeat_tick, busy
    );

endinterface

// File: rtl/evt_timer.sv
// Saturating cycle counter shared by all decoder states.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart count at 0 next cycle (wins over en)
//   en         : advance count by one (saturates at all-ones)
//   limit      : terminal value; hit when count == limit-1
//   hit        : combinational, high for the single cycle count == limit-1 while enabled
module evt_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;

    // hit does not depend on clr so the owner may clear on hit without a loop.
    assign hit = en && (count_q == (limit - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced switch level/edge strobes into short press, long press,
// double click and (optionally) auto-repeat pulses, one cycle each.
//   clk, rst_n : clock, async active-low reset
//   bus        : button_event_decoder_if.slave (inputs level/trans_up/trans_dn,
//                registered outputs short_press/long_press/double_click/repeat_tick/busy)
// Build option: define AUTO_REPEAT_EN to generate repeat_tick while long-held;
// otherwise repeat_tick is tied 0 and HELD only waits for release.
// LONG_CYCLES and GAP_CYCLES must be >= 2.
module button_event_decoder
    import button_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = 32'($clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)) + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_event_decoder_if.slave  bus
);

    // Counter restarts at 0 the cycle after a state entry, so the entry cycle
    // itself is the first counted cycle for PRESS/GAP: compare one lower.
    localparam logic [CNT_W-1:0] LIM_LONG = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_GAP  = CNT_W'(GAP_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] LIM_REP  = CNT_W'(REPEAT_CYCLES);
`endif

    state_e           state_q;
    logic             short_q;
    logic             long_q;
    logic             dc_q;
    logic             busy_q;

    logic             up_only_c;
    logic             dn_only_c;
    logic             tmr_en_c;
    logic             tmr_clr_c;
    logic             tmr_dn_clr_c;
    logic [CNT_W-1:0] tmr_limit_c;
    logic             tmr_hit;

    // Simultaneous up and down strobes cancel each other.
    assign up_only_c = bus.trans_up & ~bus.trans_dn;
    assign dn_only_c = bus.trans_dn & ~bus.trans_up;

    // Timer enable/limit per state; cleared whenever idle, on terminal hit, or on release from PRESS.
    always_comb begin
        tmr_en_c     = 1'b0;
        tmr_limit_c  = LIM_LONG;
        tmr_dn_clr_c = 1'b0;
        case (state_q)
            PRESS: begin
                tmr_en_c     = 1'b1;
                tmr_limit_c  = LIM_LONG;
                tmr_dn_clr_c = dn_only_c;
            end
            GAP: begin
                tmr_en_c    = 1'b1;
                tmr_limit_c = LIM_GAP;
            end
`ifdef AUTO_REPEAT_EN
            HELD: begin
                tmr_en_c    = 1'b1;
                tmr_limit_c = LIM_REP;
            end
`endif
            default: begin
            end
        endcase
    end

    assign tmr_clr_c = ~tmr_en_c | tmr_hit | tmr_dn_clr_c;

    evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_c),
        .en    (tmr_en_c),
        .limit (tmr_limit_c),
        .hit   (tmr_hit)
    );

`ifdef AUTO_REPEAT_EN
    logic rep_q;

    // Auto-repeat pulse; release wins over a coincident period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= (state_q == HELD) && tmr_hit && !dn_only_c;
        end
    end

    assign bus.repeat_tick = rep_q;
`else
    assign bus.repeat_tick = 1'b0;
`endif

    // Gesture FSM with registered event pulses; timer limits win over coincident strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dc_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (up_only_c) begin
                        state_q <= PRESS;
                        busy_q  <= 1'b1;
                    end else if (bus.level) begin
                        // Switch already down (e.g. held through reset): swallow this press.
                        state_q <= LOCKOUT;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS: begin
                    if (tmr_hit) begin
                        long_q  <= 1'b1;
                        state_q <= HELD;
                    end else if (dn_only_c) begin
                        state_q <= GAP;
                    end
                end
                HELD: begin
                    if (dn_only_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                GAP: begin
                    if (tmr_hit) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (up_only_c) begin
                        dc_q    <= 1'b1;
                        state_q <= DC_HOLD;
                    end
                end
                DC_HOLD, LOCKOUT: begin
                    if (dn_only_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_click = dc_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: timestamp-based reference model checked on
// every cycle, directed gesture scenarios with literal expectations, then
// randomized press/release traffic with spurious strobes and async resets.
module tb_button_event_decoder;

    localparam int unsigned LONG = 8;
    localparam int unsigned GAP  = 4;
    localparam int unsigned REP  = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_CYCLES   (LONG),
        .GAP_CYCLES    (GAP),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps of accepted gestures) ----------------
    int mcyc;
    int t_press;   // cycle of accepted press edge, -1 if no press pending
    int t_rel;     // cycle of release that opened a double-click window, -1 if none
    int t_long;    // first cycle long_press was visible
    bit held, in_dc, locked;
    bit e_sp, e_lp, e_dc, e_rt, e_busy;

    always @(posedge clk or negedge rst_n) begin
        bit u, d;
        if (!rst_n) begin
            mcyc = 0; t_press = -1; t_rel = -1; t_long = 0;
            held = 0; in_dc = 0; locked = 0;
            e_sp = 0; e_lp = 0; e_dc = 0; e_rt = 0; e_busy = 0;
        end else begin
            u = bus.trans_up && !bus.trans_dn;
            d = bus.trans_dn && !bus.trans_up;
            e_sp = 0; e_lp = 0; e_dc = 0; e_rt = 0;
            if (locked) begin
                if (d) locked = 0;
            end else if (t_press >= 0) begin
                if (mcyc - t_press == int'(LONG) - 1) begin
                    e_lp = 1; held = 1; t_long = mcyc + 1; t_press = -1;
                end else if (d) begin
                    t_rel = mcyc; t_press = -1;
                end
            end else if (held) begin
                if (d) held = 0;
                else if (AR && (mcyc + 1 - t_long) > 0 && ((mcyc + 1 - t_long) % int'(REP)) == 0) e_rt = 1;
            end else if (t_rel >= 0) begin
                if (mcyc - t_rel == int'(GAP) - 1) begin
                    e_sp = 1; t_rel = -1;
                end else if (u) begin
                    e_dc = 1; in_dc = 1; t_rel = -1;
                end
            end else if (in_dc) begin
                if (d) in_dc = 0;
            end else begin
                if (u) t_press = mcyc;
                else if (bus.level) locked = 1;
            end
            e_busy = locked || (t_press >= 0) || held || (t_rel >= 0) || in_dc;
            mcyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("short_press",  bus.short_press,  e_sp);
            check("long_press",   bus.long_press,   e_lp);
            check("double_click", bus.double_click, e_dc);
            check("repeat_tick",  bus.repeat_tick,  e_rt);
            check("busy",         bus.busy,         e_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [63:0] o_sp, o_lp, o_dc, o_rt, o_busy;

    task automatic cyc(input logic u, input logic d, input logic l);
        bus.trans_up = u;
        bus.trans_dn = d;
        bus.level    = l;
        @(posedge clk);
        #1;
    endtask

    // Drives strobes at the given cycle indices (-1 = unused); o_*[k] holds outputs seen in cycle k.
    task automatic run_seq(input int u1, input int d1, input int u2, input int d2,
                           input int n, input logic lvl0);
        logic l;
        l = lvl0;
        o_sp = '0; o_lp = '0; o_dc = '0; o_rt = '0; o_busy = '0;
        for (int t = 0; t < n; t++) begin
            logic u, d;
            u = (t == u1) || (t == u2);
            d = (t == d1) || (t == d2);
            if (u && !d) l = 1'b1;
            else if (d && !u) l = 1'b0;
            cyc(u, d, l);
            o_sp[t+1]   = bus.short_press;
            o_lp[t+1]   = bus.long_press;
            o_dc[t+1]   = bus.double_click;
            o_rt[t+1]   = bus.repeat_tick;
            o_busy[t+1] = bus.busy;
        end
        bus.trans_up = 1'b0;
        bus.trans_dn = 1'b0;
    endtask

    logic ru, rd, rl;
    int   hold;
    int   r;

    initial begin
        bus.level = 1'b0; bus.trans_up = 1'b0; bus.trans_dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_short",  bus.short_press,  1'b0);
        check("rst_long",   bus.long_press,   1'b0);
        check("rst_dc",     bus.double_click, 1'b0);
        check("rst_repeat", bus.repeat_tick,  1'b0);
        check("rst_busy",   bus.busy,         1'b0);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0);

        // 1: short press
        run_seq(0, 3, -1, -1, 12, 1'b0);
        check("t1_sp_at7",   o_sp[7], 1'b1);
        check("t1_sp_once",  $countones(o_sp) == 1, 1'b1);
        check("t1_no_other", $countones(o_lp | o_dc | o_rt) == 0, 1'b1);
        check("t1_busy6",    o_busy[6], 1'b1);
        check("t1_busy8",    o_busy[8], 1'b0);

        // 2: long press then release
        run_seq(0, 12, -1, -1, 16, 1'b0);
        check("t2_lp_at8",   o_lp[8], 1'b1);
        check("t2_lp_once",  $countones(o_lp) == 1, 1'b1);
        check("t2_no_sp_dc", $countones(o_sp | o_dc) == 0, 1'b1);
        check("t2_rt_at11",  o_rt[11], AR);
        check("t2_rt_count", $countones(o_rt) == (AR ? 1 : 0), 1'b1);
        check("t2_busy12",   o_busy[12], 1'b1);
        check("t2_busy13",   o_busy[13], 1'b0);

        // 3: double click
        run_seq(0, 2, 4, 20, 24, 1'b0);
        check("t3_dc_at5",   o_dc[5], 1'b1);
        check("t3_dc_once",  $countones(o_dc) == 1, 1'b1);
        check("t3_no_sp_lp", $countones(o_sp | o_lp) == 0, 1'b1);
        check("t3_busy20",   o_busy[20], 1'b1);
        check("t3_busy21",   o_busy[21], 1'b0);

        // 4: reset while pressed -> lockout, then a normal press
        bus.level = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_seq(-1, 5, -1, -1, 10, 1'b1);
        check("t4_busy1",    o_busy[1], 1'b1);
        check("t4_busy5",    o_busy[5], 1'b1);
        check("t4_busy6",    o_busy[6], 1'b0);
        check("t4_no_event", $countones(o_sp | o_lp | o_dc | o_rt) == 0, 1'b1);
        run_seq(0, 3, -1, -1, 12, 1'b0);
        check("t4_sp_at7",   o_sp[7], 1'b1);

        // 5: simultaneous up+dn in the gap is ignored
        run_seq(0, 2, 4, 4, 10, 1'b0);
        check("t5_sp_at6",   o_sp[6], 1'b1);
        check("t5_no_dc",    $countones(o_dc) == 0, 1'b1);

        // 6: auto-repeat while held
        run_seq(0, 18, -1, -1, 24, 1'b0);
        check("t6_lp_at8",   o_lp[8], 1'b1);
        check("t6_rt_11",    o_rt[11], AR);
        check("t6_rt_14",    o_rt[14], AR);
        check("t6_rt_17",    o_rt[17], AR);
        check("t6_rt_count", $countones(o_rt) == (AR ? 3 : 0), 1'b1);
        check("t6_busy19",   o_busy[19], 1'b0);

        // 7: release on the long limit cycle -> long wins; a later stray release exits
        run_seq(0, 7, -1, 10, 14, 1'b0);
        check("t7_lp_at8",   o_lp[8], 1'b1);
        check("t7_no_sp",    $countones(o_sp | o_rt) == 0, 1'b1);
        check("t7_busy11",   o_busy[11], 1'b0);

        // 8: second press on the gap limit cycle -> short wins, press swallowed
        run_seq(0, 2, 5, 8, 12, 1'b0);
        check("t8_sp_at6",   o_sp[6], 1'b1);
        check("t8_no_dc",    $countones(o_dc) == 0, 1'b1);
        check("t8_busy7",    o_busy[7], 1'b1);
        check("t8_busy9",    o_busy[9], 1'b0);

        // Randomized traffic around the timing limits
        rl = 1'b0;
        hold = 3;
        for (int i = 0; i < 4000; i++) begin
            ru = 1'b0;
            rd = 1'b0;
            if (hold == 0) begin
                rl = ~rl;
                if (rl) ru = 1'b1;
                else    rd = 1'b1;
                hold = rl ? $urandom_range(1, 12) : $urandom_range(1, 7);
            end else begin
                hold--;
            end
            r = $urandom_range(0, 199);
            if (r < 5) begin
                ru = 1'b1;
                rd = 1'b1;
            end else if (r < 11) begin
                if (rl) ru = 1'b1;
                else    rd = 1'b1;
            end else if (r == 199) begin
                rst_n = 1'b0;
                #3;
                rst_n = 1'b1;
            end
            cyc(ru, rd, rl);
        end
        repeat (20) cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
